// File: rtl/alu.sv
// 64-bit add/sub/and/xor ALU with signed-overflow flag, registered result and sticky overflow.
// Latency: C/Overflow combinational (0 cycles); C_q/Overflow_sticky 1 cycle after the inputs.
// Backpressure: none; a new operation is taken whenever A, B or Control change.

// 4-bit carry-lookahead group: all internal carries derived in parallel from cin.
module alu_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:1] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flattened lookahead equations so no carry depends on another carry in this group.
  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign s    = p ^ {c[3:1], cin};
  assign cout = c[4];

endmodule

module alu (
  output logic [63:0] C,
  output logic        Overflow,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [1:0]  Control,
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] C_q,
  output logic        Overflow_sticky
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Subtract reuses the adder: A + ~B + 1, with the +1 entering as carry-in.
  logic        sub;
  logic        arith;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic [16:0] carry;
  logic        carry_into_msb;

  assign sub   = (Control == OP_SUB);
  assign arith = (Control == OP_ADD) || (Control == OP_SUB);
  assign b_eff = sub ? ~B : B;

  assign carry[0] = sub;

  // Sixteen lookahead groups with the carry rippling group to group.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cla
      alu_cla4 u_cla4 (
        .a    (A[gi*4 +: 4]),
        .b    (b_eff[gi*4 +: 4]),
        .cin  (carry[gi]),
        .s    (sum[gi*4 +: 4]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Carry into bit 63 is recovered from the sum bit itself (s = a ^ b ^ cin),
  // so the groups need not export their internal carries. Signed overflow is
  // then the disagreement between carry into and carry out of the sign bit,
  // which covers both add and subtract because B is already inverted for sub.
  assign carry_into_msb = A[63] ^ b_eff[63] ^ sum[63];

  // Result select and overflow qualification; logic ops never overflow.
  always_comb begin
    C        = sum;
    Overflow = 1'b0;
    case (Control)
      OP_ADD,
      OP_SUB: begin
        C        = sum;
        Overflow = arith & (carry[16] ^ carry_into_msb);
      end
      OP_AND: C = A & B;
      OP_XOR: C = A ^ B;
      default: begin
        C        = sum;
        Overflow = 1'b0;
      end
    endcase
  end

  // Status registers: result snapshot and sticky overflow; reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      C_q             <= 64'd0;
      Overflow_sticky <= 1'b0;
    end else begin
      C_q             <= C;
      Overflow_sticky <= Overflow_sticky | Overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: combinational result/overflow and registered status path.
// Latency: each operation checks C/Overflow 5 units after drive, C_q/sticky 1 unit after the edge.
// Backpressure: none; one operation per clock.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] A;
  logic [63:0] B;
  logic [1:0]  Control;
  logic [63:0] C;
  logic        Overflow;
  logic [63:0] C_q;
  logic        Overflow_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] cq_exp_q[$];
  logic        sticky_exp = 1'b0;

  alu dut (
    .C               (C),
    .Overflow        (Overflow),
    .A               (A),
    .B               (B),
    .Control         (Control),
    .clk             (clk),
    .rst             (rst),
    .C_q             (C_q),
    .Overflow_sticky (Overflow_sticky)
  );

  always #6 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: sign-extend to 65 bits; signed overflow when bits 64 and 63 disagree.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] ctl);
    logic [64:0] ext;
    logic [63:0] c;
    logic        ov;
    ext = 65'd0;
    c   = 64'd0;
    ov  = 1'b0;
    case (ctl)
      2'b00: begin ext = {a[63], a} + {b[63], b}; c = ext[63:0]; ov = ext[64] ^ ext[63]; end
      2'b01: begin ext = {a[63], a} - {b[63], b}; c = ext[63:0]; ov = ext[64] ^ ext[63]; end
      2'b10: c = a & b;
      default: c = a ^ b;
    endcase
    return {ov, c};
  endfunction

  task automatic op(input logic r, input logic [63:0] a, input logic [63:0] b,
                    input logic [1:0] ctl, input logic [63:0] exp_c, input logic exp_ov,
                    input string tag);
    logic [63:0] exp_q;
    @(negedge clk);
    rst     = r;
    A       = a;
    B       = b;
    Control = ctl;
    cq_exp_q.push_back(r ? 64'd0 : exp_c);
    sticky_exp = r ? 1'b0 : (sticky_exp | exp_ov);
    #5;
    check({tag, ".C"}, C, exp_c);
    check({tag, ".Overflow"}, {63'd0, Overflow}, {63'd0, exp_ov});
    @(posedge clk);
    #1;
    if (cq_exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.C_q: got %h expected <scoreboard empty>", tag, C_q);
    end else begin
      exp_q = cq_exp_q.pop_front();
      check({tag, ".C_q"}, C_q, exp_q);
    end
    check({tag, ".sticky"}, {63'd0, Overflow_sticky}, {63'd0, sticky_exp});
  endtask

  initial begin
    logic [64:0] m;
    rst     = 1'b1;
    A       = 64'd0;
    B       = 64'd0;
    Control = 2'b00;

    // Reset held for an edge: registers read zero.
    op(1'b1, 64'd0, 64'd0, 2'b00, 64'd0, 1'b0, "reset");

    // Sweep of all four operations over small positive operands.
    for (int ctl = 0; ctl < 4; ctl++) begin
      for (int a = 1; a <= 100; a++) begin
        for (int b = 1; b <= 100; b++) begin
          m = model(64'(a), 64'(b), 2'(ctl));
          op(1'b0, 64'(a), 64'(b), 2'(ctl), m[63:0], m[64], "sweep");
        end
      end
    end

    // Directed corner cases with literal expectations.
    op(1'b0, 64'd1, 64'd100, 2'b01, 64'hFFFF_FFFF_FFFF_FF9D, 1'b0, "sub_wrap");
    op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 1'b1, "add_ovf");
    op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b10, 64'd1, 1'b0, "and_after_ovf");
    op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b11, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, "xor");
    op(1'b0, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "sub_ovf");
    op(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'd0, 1'b1, "neg_add_ovf");
    op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00,
       64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "neg_add_ok");
    // Reset coincident with an overflowing op: reset wins, comb path unaffected.
    op(1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "rst_vs_ovf");
    op(1'b0, 64'd5, 64'd3, 2'b01, 64'd2, 1'b0, "post_rst");
    op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 1'b1, "ovf_again");
    op(1'b1, 64'd0, 64'd0, 2'b00, 64'd0, 1'b0, "final_rst");

    if (cq_exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", cq_exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

64-bit, four-function arithmetic/logic unit: add, subtract, bitwise AND and bitwise XOR on two 64-bit operands, with a signed-overflow indication. The result path is purely combinational and serves as the datapath execute stage. A small clocked section registers the result and keeps a sticky overflow flag for status readout.

## Interface
Parameters:
- none; all widths are fixed at 64 bits.

Ports (declaration order: C, Overflow, A, B, Control, clk, rst, C_q, Overflow_sticky; existing positional instantiations of the first five ports stay valid):
- clk  input  1  sole clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- C  output  64  combinational result.
- Overflow  output  1  combinational signed-overflow flag for the current operation.
- A  input  64  operand A.
- B  input  64  operand B.
- Control  input  2  operation select: 00 add, 01 subtract, 10 AND, 11 XOR.
- C_q  output  64  C registered on each rising clk edge.
- Overflow_sticky  output  1  set when Overflow is 1 at a rising edge; cleared only by rst.

## Operation
- Control 00: C = (A + B) mod 2^64.
- Control 01: C = (A − B) mod 2^64. Computed as A + ~B + 1 on the same adder as add, using one shared 64-bit adder with carry-in.
- Control 10: C = A & B.
- Control 11: C = A ^ B.
- Adder structure: 16 cascaded 4-bit carry-lookahead groups, with the carry rippling between groups. Carry-out is internal only and is not exported.
- Overflow (two's-complement):
  - add: operands have the same sign and C's sign differs from it.
  - subtract: operands have different signs and C's sign differs from A's.
  - AND, XOR: Overflow = 0.
- Unsigned wrap is not flagged. For example, 1 − 100 gives C = 2^64 − 99 with Overflow = 0.
- No undefined Control codes exist; all four are decoded. If Control contains X, C may be X.
- Clocked section, at each rising clk edge:
  - if rst: C_q ← 0 and Overflow_sticky ← 0;
  - otherwise: C_q ← C and Overflow_sticky ← Overflow_sticky | Overflow.
- Reset values: C_q = 0, Overflow_sticky = 0. C and Overflow are not affected by reset; they follow the inputs at all times.

## Timing
- C and Overflow are combinational from A, B and Control, with zero clock latency. They must settle within 5 time units of an input change in zero-delay simulation (in practice, immediately).
- C_q and Overflow_sticky have 1-cycle latency from the inputs.
- If rst is asserted in the same cycle that Overflow = 1, reset wins and the sticky flag reads 0 after the edge.
- A rst pulse mid-stream clears the registers only; the combinational outputs continue uninterrupted.
- No handshake: a new operation is accepted whenever the inputs change.

## Test plan
- Exhaustive sweep: for each Control 0–3, A = 1..100, B = 1..100, wait 5 units and compare C with A+B, A−B, A&B, A^B respectively. Required: 40000 correct, 0 wrong.
- Subtract wrap: A = 1, B = 100, Control = 01 → C = 0xFFFF_FFFF_FFFF_FF9D, Overflow = 0.
- Signed add overflow: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, Control = 00 → C = 0x8000_0000_0000_0000, Overflow = 1. Same operands with Control = 10 → C = 1, Overflow = 0.
- Signed subtract overflow: A = 0x8000_0000_0000_0000, B = 1, Control = 01 → C = 0x7FFF_FFFF_FFFF_FFFF, Overflow = 1.
- Registered path:
  - with rst = 1 for one edge → C_q = 0, Overflow_sticky = 0;
  - release rst and apply the overflow case above → after the next edge C_q = 0x8000_0000_0000_0000, Overflow_sticky = 1;
  - apply a non-overflow op → sticky flag stays 1;
  - assert rst → flag is 0 after the edge.
